// File: rtl/puf_resp_voter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : puf_resp_voter
// Purpose  : Evaluates a PUF NUM_EVAL times and majority-votes each response bit.
// Revision : 1.0
// ============================================================================
module puf_resp_voter #(
  parameter int RESP_W   = 256,
  parameter int CHAL_W   = 128,
  parameter int NUM_EVAL = 5,
  parameter int TIMEOUT  = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [CHAL_W-1:0]            challenge_i,
  output logic                         puf_enable_o,
  output logic                         puf_mode_o,
  output logic                         puf_ready_cha_o,
  output logic [CHAL_W-1:0]            puf_challenge_o,
  input  logic                         puf_resp_valid_i,
  input  logic [RESP_W-1:0]            puf_resp_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [RESP_W-1:0]            key_o,
  output logic                         key_valid_o,
  output logic [$clog2(RESP_W+1)-1:0]  unstable_o,
  output logic                         timeout_err_o
);

  localparam int CNT_W = $clog2(NUM_EVAL + 1);
  localparam int UNS_W = $clog2(RESP_W + 1);
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    ACCUM = 3'd3,
    FINAL = 3'd4
  } state_t;

  state_t             state;
  logic [CHAL_W-1:0]  chal;
  logic [CNT_W-1:0]   cnt [RESP_W];
  logic [CNT_W-1:0]   eval_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               valid_q;
  logic [RESP_W-1:0]  resp_q;
  logic [RESP_W-1:0]  key;
  logic [UNS_W-1:0]   unstable;
  logic               key_valid;
  logic               timeout_err;

  logic               resp_edge;
  logic               tmo_hit;
  logic [CNT_W-1:0]   eval_nxt;
  logic [RESP_W-1:0]  key_nxt;
  logic [UNS_W-1:0]   unst_nxt;

  assign resp_edge = puf_resp_valid_i & ~valid_q;
  assign tmo_hit   = (state == WAIT) && !resp_edge && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign eval_nxt  = eval_cnt + CNT_W'(1);

  always_comb begin
    key_nxt  = '0;
    unst_nxt = '0;
    for (int i = 0; i < RESP_W; i++) begin
      key_nxt[i] = (cnt[i] > CNT_W'(NUM_EVAL / 2));
      if ((cnt[i] != '0) && (cnt[i] != CNT_W'(NUM_EVAL)))
        unst_nxt = unst_nxt + UNS_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      chal        <= '0;
      eval_cnt    <= '0;
      tmo_cnt     <= '0;
      valid_q     <= 1'b0;
      resp_q      <= '0;
      key         <= '0;
      unstable    <= '0;
      key_valid   <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < RESP_W; i++) cnt[i] <= '0;
    end else begin
      // Tracking the live level (also during ISSUE) means a valid that is
      // already high when WAIT begins never looks like a fresh edge.
      valid_q <= puf_resp_valid_i;
      case (state)
        IDLE: begin
          if (start_i) begin
            chal        <= challenge_i;
            eval_cnt    <= '0;
            key_valid   <= 1'b0;
            timeout_err <= 1'b0;
            for (int i = 0; i < RESP_W; i++) cnt[i] <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (resp_edge) begin
            resp_q <= puf_resp_i;
            state  <= ACCUM;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ACCUM: begin
          for (int i = 0; i < RESP_W; i++) cnt[i] <= cnt[i] + CNT_W'(resp_q[i]);
          eval_cnt <= eval_nxt;
          state    <= (eval_nxt == CNT_W'(NUM_EVAL)) ? FINAL : ISSUE;
        end
        FINAL: begin
          key       <= key_nxt;
          unstable  <= unst_nxt;
          key_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign puf_enable_o    = (state == ISSUE) || (state == WAIT) || (state == ACCUM);
  assign puf_mode_o      = 1'b0;
  assign puf_ready_cha_o = (state == ISSUE);
  assign puf_challenge_o = chal;
  assign busy_o          = (state != IDLE);
  // Completion is flagged in the cycle the FSM is still in FINAL or timing out in WAIT.
  assign done_o          = (state == FINAL) || tmo_hit;
  assign key_o           = key;
  assign key_valid_o     = key_valid;
  assign unstable_o      = unstable;
  assign timeout_err_o   = timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_puf_resp_voter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_puf_resp_voter
// Purpose  : Scoreboard bench for puf_resp_voter with a behavioural PUF responder.
// Revision : 1.0
// ============================================================================
module tb_puf_resp_voter;

  localparam int RESP_W   = 256;
  localparam int CHAL_W   = 128;
  localparam int NUM_EVAL = 5;
  localparam int TIMEOUT  = 1024;
  localparam int UNS_W    = $clog2(RESP_W + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [CHAL_W-1:0]  challenge;
  logic               puf_enable;
  logic               puf_mode;
  logic               puf_ready_cha;
  logic [CHAL_W-1:0]  puf_challenge;
  logic               puf_resp_valid;
  logic [RESP_W-1:0]  puf_resp;
  logic               busy;
  logic               done;
  logic [RESP_W-1:0]  key;
  logic               key_valid;
  logic [UNS_W-1:0]   unstable;
  logic               timeout_err;

  puf_resp_voter #(
    .RESP_W(RESP_W), .CHAL_W(CHAL_W), .NUM_EVAL(NUM_EVAL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .challenge_i(challenge),
    .puf_enable_o(puf_enable), .puf_mode_o(puf_mode), .puf_ready_cha_o(puf_ready_cha),
    .puf_challenge_o(puf_challenge), .puf_resp_valid_i(puf_resp_valid), .puf_resp_i(puf_resp),
    .busy_o(busy), .done_o(done), .key_o(key), .key_valid_o(key_valid),
    .unstable_o(unstable), .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [RESP_W-1:0] key;
    int                unstable;
    bit                tmo;
    int                lat;
  } exp_t;

  exp_t              sb_q[$];
  logic [RESP_W-1:0] resp_fifo[$];
  int                model_mode = 0;   // 0 normal, 1 silent, 2 stale-high valid
  int                start_cyc  = 0;
  int                n_checks   = 0;
  int                n_errors   = 0;

  localparam logic [CHAL_W-1:0] CHAL_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [CHAL_W-1:0] CHAL_B = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

  task automatic check(input string tag, input logic [RESP_W-1:0] obs, input logic [RESP_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic [CHAL_W-1:0] c);
    @(negedge clk);
    start     = 1'b1;
    challenge = c;
    start_cyc = cyc;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic push_exp(input logic [RESP_W-1:0] k, input int u, input bit t, input int l);
    exp_t e;
    e.key = k; e.unstable = u; e.tmo = t; e.lat = l;
    sb_q.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
    check("wait_done", RESP_W'(sb_q.size()), '0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ready();
    int i;
    for (i = 0; i < 200 && !puf_ready_cha; i++) @(negedge clk);
    check("ready_seen", RESP_W'(puf_ready_cha), RESP_W'(1));
  endtask

  // Behavioural PUF: answers each challenge-ready pulse according to model_mode.
  initial begin
    puf_resp_valid = 1'b0;
    puf_resp       = '0;
    forever begin
      @(negedge clk);
      if (puf_ready_cha) begin
        if (model_mode == 0) begin
          repeat (3) @(negedge clk);
          puf_resp_valid = 1'b1;
          puf_resp       = (resp_fifo.size() > 0) ? resp_fifo.pop_front() : '0;
          @(negedge clk);
          puf_resp_valid = 1'b0;
        end else if (model_mode == 2) begin
          puf_resp = '1;
          repeat (2) @(negedge clk);
          puf_resp_valid = 1'b0;
          repeat (2) @(negedge clk);
          puf_resp_valid = 1'b1;
          puf_resp       = (resp_fifo.size() > 0) ? resp_fifo.pop_front() : '0;
        end
      end
    end
  end

  // Scoreboard monitor: pops an expectation on every done pulse.
  initial begin
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if (done) begin
        lat = cyc - start_cyc + 1;
        if (sb_q.size() == 0) begin
          check("done_without_expect", RESP_W'(sb_q.size()), RESP_W'(1));
        end else begin
          e = sb_q.pop_front();
          check("latency", RESP_W'(lat), RESP_W'(e.lat));
          @(negedge clk);
          check("done_one_cycle", RESP_W'(done), '0);
          check("busy_after_done", RESP_W'(busy), '0);
          check("key_valid", RESP_W'(key_valid), RESP_W'(!e.tmo));
          check("timeout_err", RESP_W'(timeout_err), RESP_W'(e.tmo));
          if (!e.tmo) begin
            check("key", key, e.key);
            check("unstable", RESP_W'(unstable), RESP_W'(e.unstable));
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"},      RESP_W'(busy), '0);
    check({pfx, "_done"},      RESP_W'(done), '0);
    check({pfx, "_key"},       key, '0);
    check({pfx, "_unstable"},  RESP_W'(unstable), '0);
    check({pfx, "_key_valid"}, RESP_W'(key_valid), '0);
    check({pfx, "_tmo_err"},   RESP_W'(timeout_err), '0);
    check({pfx, "_enable"},    RESP_W'(puf_enable), '0);
    check({pfx, "_ready"},     RESP_W'(puf_ready_cha), '0);
    check({pfx, "_chal"},      RESP_W'(puf_challenge), '0);
    check({pfx, "_mode"},      RESP_W'(puf_mode), '0);
  endtask

  task automatic load_same(input logic [RESP_W-1:0] r);
    resp_fifo.delete();
    for (int i = 0; i < NUM_EVAL; i++) resp_fifo.push_back(r);
  endtask

  initial begin
    logic [RESP_W-1:0] r_a5;
    logic [RESP_W-1:0] r_3c;
    logic [RESP_W-1:0] r_5f;
    r_a5 = {32{8'hA5}};
    r_3c = {32{8'h3C}};
    r_5f = {64{4'h5}} ^ {RESP_W{1'b1}};
    rst = 1'b1; start = 1'b0; challenge = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Unanimous vote, then confirm the result holds.
    load_same(r_a5);
    push_exp(r_a5, 0, 1'b0, NUM_EVAL * (2 + 3) + 2);
    drive_start(CHAL_A);
    check("chal_captured", RESP_W'(puf_challenge), RESP_W'(CHAL_A));
    check("enable_in_issue", RESP_W'(puf_enable), RESP_W'(1));
    check("busy_running", RESP_W'(busy), RESP_W'(1));
    wait_done();
    repeat (5) @(negedge clk);
    check("key_hold", key, r_a5);
    check("key_valid_hold", RESP_W'(key_valid), RESP_W'(1));

    // Noisy bits 0 and 1; a start coincident with done must be dropped.
    resp_fifo.delete();
    resp_fifo.push_back(RESP_W'(1));
    resp_fifo.push_back(RESP_W'(0));
    resp_fifo.push_back(RESP_W'(3));
    resp_fifo.push_back(RESP_W'(0));
    resp_fifo.push_back(RESP_W'(1));
    push_exp(RESP_W'(1), 2, 1'b0, 27);
    drive_start(CHAL_B);
    repeat (25) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Silent PUF: timeout after 1 + 1 + TIMEOUT cycles.
    model_mode = 1;
    push_exp('0, 0, 1'b1, 1 + 1 + TIMEOUT);
    drive_start(CHAL_A);
    wait_done();

    // Valid held high through ISSUE must not be counted as a response.
    model_mode = 2;
    load_same(r_3c);
    puf_resp_valid = 1'b1;
    push_exp(r_3c, 0, 1'b0, NUM_EVAL * (2 + 4) + 2);
    drive_start(CHAL_B);
    wait_done();
    puf_resp_valid = 1'b0;
    model_mode = 0;
    repeat (3) @(negedge clk);

    // Reset during the third WAIT, then a clean vote.
    load_same(r_a5);
    drive_start(CHAL_A);
    wait_ready();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      wait_ready();
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midrst");
    repeat (5) @(negedge clk);
    load_same(r_5f);
    push_exp(r_5f, 0, 1'b0, 27);
    drive_start(CHAL_B);
    wait_done();

    // Start during ACCUM with another challenge is ignored.
    load_same(r_a5);
    push_exp(r_a5, 0, 1'b0, 27);
    drive_start(CHAL_A);
    wait_ready();
    repeat (4) @(negedge clk);
    start = 1'b1; challenge = CHAL_B;
    @(negedge clk);
    start = 1'b0;
    check("chal_kept", RESP_W'(puf_challenge), RESP_W'(CHAL_A));
    wait_done();
    check("chal_kept_end", RESP_W'(puf_challenge), RESP_W'(CHAL_A));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
